fifo_reader: RTL and testbench

Read-side controller for the 6-bit FIFO. It drains the FIFO by issuing `pop` and absorbs the one-cycle memory read latency in a 3-entry output buffer. It presents words downstream over a valid/ready handshake and keeps a wrapping count of delivered words. It sits between the FIFO's read port and the next consumer stage, and it is the counterpart of the upstream writer that honours `Pausa`.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/fifo_reader_if.sv | 25 ++
 rtl/fifo_reader_buf.sv | 65 ++++++
 rtl/fifo_reader.sv | 63 ++++++
 tb/tb_fifo_reader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared widths and buffer-state encoding for the FIFO read path.
// Also holds the small helpers for the 3-entry circular buffer.
package fifo_pkg;
   localparam int DATA_WIDTH = 6;
   localparam int BUF_DEPTH  = 3;
   localparam int CNT_WIDTH  = 8;
   localparam int IDX_WIDTH  = 2;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_PART  = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   function automatic buf_state_e buf_state_of(input logic [IDX_WIDTH-1:0] occ);
      buf_state_e st;
      case (occ)
         2'd0:    st = BUF_EMPTY;
         2'd3:    st = BUF_FULL;
         default: st = BUF_PART;
      endcase
      return st;
   endfunction

   // Index wraps 2 -> 0; value 3 is never used.
   function automatic logic [IDX_WIDTH-1:0] idx_next(input logic [IDX_WIDTH-1:0] idx);
      logic [IDX_WIDTH-1:0] nxt;
      if (idx == IDX_WIDTH'(BUF_DEPTH - 1)) begin
         nxt = 2'd0;
      end else begin
         nxt = idx + 2'd1;
      end
      return nxt;
   endfunction
endpackage

// File: rtl/fifo_reader_if.sv
// Handshake bundle between the FIFO read port, the reader and the consumer.
// master is the reader's view; slave is the environment's view.
interface fifo_reader_if;
   import fifo_pkg::*;

   logic                  enable;
   logic                  Fifo_Empty;
   logic                  Almost_Empty;
   logic [DATA_WIDTH-1:0] Fifo_Data_out;
   logic                  pop;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  ready_in;
   logic [CNT_WIDTH-1:0]  rd_count;

   modport master (
      input  enable, Fifo_Empty, Almost_Empty, Fifo_Data_out, ready_in,
      output pop, data_out, valid_out, rd_count
   );

   modport slave (
      output enable, Fifo_Empty, Almost_Empty, Fifo_Data_out, ready_in,
      input  pop, data_out, valid_out, rd_count
   );
endinterface

// File: rtl/fifo_reader_buf.sv
// Three-entry circular output buffer that absorbs the FIFO read latency.
// Writes in FULL and reads in EMPTY are ignored as a defensive guard.
module fifo_reader_buf
   import fifo_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] head,
   output logic [IDX_WIDTH-1:0]  occ
);
   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [IDX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
   logic [IDX_WIDTH-1:0]  rd_idx_q, rd_idx_d;
   logic [IDX_WIDTH-1:0]  occ_q, occ_d;
   buf_state_e            state_s;
   logic                  wr_ok_s;
   logic                  rd_ok_s;

   // Next indices and occupancy from the buffer state.
   always_comb begin
      state_s = buf_state_of(occ_q);
      wr_ok_s = wr_en & (state_s != BUF_FULL);
      rd_ok_s = rd_en & (state_s != BUF_EMPTY);
      if (wr_ok_s) begin
         wr_idx_d = idx_next(wr_idx_q);
      end else begin
         wr_idx_d = wr_idx_q;
      end
      if (rd_ok_s) begin
         rd_idx_d = idx_next(rd_idx_q);
      end else begin
         rd_idx_d = rd_idx_q;
      end
      case ({wr_ok_s, rd_ok_s})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // Storage, indices and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_idx_q <= 2'd0;
         rd_idx_q <= 2'd0;
         occ_q    <= 2'd0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         occ_q    <= occ_d;
         if (wr_ok_s) begin
            mem_q[wr_idx_q] <= wr_data;
         end
      end
   end

   assign head = mem_q[rd_idx_q];
   assign occ  = occ_q;
endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side controller: issues pops, buffers returning words and
// delivers them over valid/ready while counting deliveries.
module fifo_reader
   import fifo_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   fifo_reader_if.master bus
);
   logic                  inflight_q, inflight_d;
   logic                  armed_q, armed_d;
   logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
   logic [IDX_WIDTH-1:0]  occ_s;
   logic [DATA_WIDTH-1:0] head_s;
   logic                  valid_s;
   logic                  xfer_s;
   logic                  room_s;
   logic                  pop_s;

   fifo_reader_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (inflight_q),
      .wr_data (bus.Fifo_Data_out),
      .rd_en   (xfer_s),
      .head    (head_s),
      .occ     (occ_s)
   );

   // Pop decision uses registered state and FIFO flags only, never ready_in.
   always_comb begin
      valid_s    = (occ_s != 2'd0);
      xfer_s     = valid_s & bus.ready_in;
      room_s     = (({1'b0, occ_s} + {2'b00, inflight_q}) < 3'(BUF_DEPTH));
      pop_s      = armed_q & bus.enable & ~bus.Fifo_Empty
                 & ~(inflight_q & bus.Almost_Empty) & room_s;
      inflight_d = pop_s;
      armed_d    = 1'b1;
      if (xfer_s) begin
         rd_count_d = rd_count_q + CNT_WIDTH'(1);
      end else begin
         rd_count_d = rd_count_q;
      end
   end

   // armed_q holds off pops for the first clock after reset release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_q <= 1'b0;
         armed_q    <= 1'b0;
         rd_count_q <= '0;
      end else begin
         inflight_q <= inflight_d;
         armed_q    <= armed_d;
         rd_count_q <= rd_count_d;
      end
   end

   assign bus.pop       = pop_s;
   assign bus.data_out  = head_s;
   assign bus.valid_out = valid_s;
   assign bus.rd_count  = rd_count_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: environment FIFO with one-cycle-stale flags, a
// queue-based reference model checked every cycle, plus directed pins.
module tb_fifo_reader;
   import fifo_pkg::*;

   logic clk;
   logic reset;

   fifo_reader_if bus_if ();

   fifo_reader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Environment FIFO contents and words waiting to be written into it.
   logic [DATA_WIDTH-1:0] fq[$];
   logic [DATA_WIDTH-1:0] pend_q[$];
   int                    flag_cnt;

   // Reference model: source order, buffered words, word in flight, count.
   logic [DATA_WIDTH-1:0] m_src[$];
   logic [DATA_WIDTH-1:0] mq[$];
   logic                  m_infl;
   logic                  m_armed;
   logic [DATA_WIDTH-1:0] m_word;
   logic [CNT_WIDTH-1:0]  m_cnt;

   // Observations for the directed pins.
   logic [DATA_WIDTH-1:0] got_q[$];
   int                    pops_seen;
   logic [31:0]           pop_vec;
   logic [31:0]           valid_vec;
   int                    step_idx;
   logic [CNT_WIDTH-1:0]  prev_cnt;
   bit                    wrapped;
   int                    n_pushed;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_infl  = 1'b0;
      m_armed = 1'b0;
      m_word  = '0;
      m_cnt   = '0;
   endtask

   task automatic clr_obs();
      got_q.delete();
      pops_seen = 0;
      pop_vec   = 32'd0;
      valid_vec = 32'd0;
      step_idx  = 0;
   endtask

   task automatic push_word(input logic [DATA_WIDTH-1:0] w);
      pend_q.push_back(w);
   endtask

   // One clock: compare at negedge+1, then advance model and environment.
   task automatic step();
      logic                  m_pop;
      logic                  m_valid;
      logic                  r_in;
      logic                  d_pop;
      logic [DATA_WIDTH-1:0] w;
      @(negedge clk);
      #1;
      r_in    = bus_if.ready_in;
      m_valid = (mq.size() != 0);
      m_pop   = m_armed && bus_if.enable && !bus_if.Fifo_Empty
                && !(m_infl && bus_if.Almost_Empty)
                && ((mq.size() + int'(m_infl)) < BUF_DEPTH);
      chk("pop", 32'(bus_if.pop), 32'(m_pop));
      chk("valid_out", 32'(bus_if.valid_out), 32'(m_valid));
      if (m_valid) chk("data_out", 32'(bus_if.data_out), 32'(mq[0]));
      chk("rd_count", 32'(bus_if.rd_count), 32'(m_cnt));
      d_pop = bus_if.pop;
      if (step_idx < 32) begin
         pop_vec[step_idx]   = d_pop;
         valid_vec[step_idx] = bus_if.valid_out;
      end
      if (d_pop) pops_seen++;
      if (bus_if.valid_out && r_in) got_q.push_back(bus_if.data_out);
      prev_cnt = bus_if.rd_count;
      step_idx++;

      @(posedge clk);
      #1;
      if (m_valid && r_in) begin
         w = mq.pop_front();
         m_cnt++;
      end
      if (m_infl) mq.push_back(m_word);
      m_infl = m_pop;
      if (m_pop) m_word = (m_src.size() != 0) ? m_src.pop_front() : '0;
      m_armed = 1'b1;

      flag_cnt = fq.size();
      if (d_pop) begin
         chk("no_underflow", 32'(fq.size() != 0), 32'd1);
         if (fq.size() != 0) bus_if.Fifo_Data_out = fq.pop_front();
      end
      while (pend_q.size() != 0) begin
         w = pend_q.pop_front();
         fq.push_back(w);
         m_src.push_back(w);
      end
      bus_if.Fifo_Empty   = (flag_cnt == 0);
      bus_if.Almost_Empty = (flag_cnt == 1);
      if (prev_cnt == 8'hFF && bus_if.rd_count == 8'h00) wrapped = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Called at posedge+1: reset asserted away from any edge.
   task automatic do_reset_mid();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_pop", 32'(bus_if.pop), 32'd0);
      chk("rst_valid", 32'(bus_if.valid_out), 32'd0);
      chk("rst_data", 32'(bus_if.data_out), 32'd0);
      chk("rst_count", 32'(bus_if.rd_count), 32'd0);
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
   endtask

   initial begin
      reset                = 1'b1;
      bus_if.enable        = 1'b0;
      bus_if.ready_in      = 1'b0;
      bus_if.Fifo_Empty    = 1'b1;
      bus_if.Almost_Empty  = 1'b0;
      bus_if.Fifo_Data_out = '0;
      flag_cnt             = 0;
      wrapped              = 1'b0;
      prev_cnt             = '0;
      n_pushed             = 0;
      model_clear();
      clr_obs();
      #1;
      chk("init_pop", 32'(bus_if.pop), 32'd0);
      chk("init_valid", 32'(bus_if.valid_out), 32'd0);
      chk("init_data", 32'(bus_if.data_out), 32'd0);
      chk("init_count", 32'(bus_if.rd_count), 32'd0);
      @(posedge clk);
      #3;
      reset = 1'b0;

      // Throughput: four words stream back to back.
      for (int i = 1; i <= 4; i++) push_word(6'(i));
      bus_if.ready_in = 1'b1;
      run(2);
      bus_if.enable = 1'b1;
      clr_obs();
      run(8);
      #1;
      chk("tp_pops", 32'(pops_seen), 32'd4);
      chk("tp_pop_vec", pop_vec, 32'h0000_000F);
      chk("tp_valid_vec", valid_vec, 32'h0000_003C);
      chk("tp_len", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) chk("tp_word", 32'(got_q[i]), 32'(i + 1));
      chk("tp_count", 32'(bus_if.rd_count), 32'd4);

      // Back-pressure: three pops fill the buffer, head holds.
      for (int i = 1; i <= 4; i++) push_word(6'(i));
      bus_if.enable   = 1'b0;
      bus_if.ready_in = 1'b0;
      run(2);
      bus_if.enable = 1'b1;
      clr_obs();
      run(6);
      #1;
      chk("bp_pops", 32'(pops_seen), 32'd3);
      chk("bp_pop_vec", pop_vec, 32'h0000_0007);
      chk("bp_valid", 32'(bus_if.valid_out), 32'd1);
      chk("bp_head", 32'(bus_if.data_out), 32'h01);
      bus_if.ready_in = 1'b1;
      clr_obs();
      run(6);
      #1;
      chk("bp_resume_vec", pop_vec, 32'h0000_0002);
      chk("bp_len", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) chk("bp_word", 32'(got_q[i]), 32'(i + 1));
      chk("bp_count", 32'(bus_if.rd_count), 32'd8);

      // Last-word guard: a single word is popped exactly once.
      push_word(6'h2A);
      bus_if.enable = 1'b0;
      run(2);
      bus_if.enable = 1'b1;
      clr_obs();
      run(5);
      #1;
      chk("lw_pops", 32'(pops_seen), 32'd1);
      chk("lw_pop_vec", pop_vec, 32'h0000_0001);
      chk("lw_len", 32'(got_q.size()), 32'd1);
      if (got_q.size() != 0) chk("lw_word", 32'(got_q[0]), 32'h2A);

      // Enable drop right after a pop.
      for (int i = 0; i < 4; i++) push_word(6'(8'h10 + i));
      bus_if.enable = 1'b0;
      run(2);
      bus_if.enable = 1'b1;
      clr_obs();
      run(1);
      bus_if.enable = 1'b0;
      run(5);
      #1;
      chk("en_pops", 32'(pops_seen), 32'd1);
      chk("en_pop_vec", pop_vec, 32'h0000_0001);
      chk("en_len", 32'(got_q.size()), 32'd1);
      if (got_q.size() != 0) chk("en_word", 32'(got_q[0]), 32'h10);
      chk("en_count", 32'(bus_if.rd_count), 32'd10);

      // Reset mid-operation with a loaded buffer and a word in flight.
      push_word(6'h20);
      push_word(6'h21);
      bus_if.enable   = 1'b1;
      bus_if.ready_in = 1'b0;
      run(3);
      do_reset_mid();
      bus_if.ready_in = 1'b1;
      clr_obs();
      run(5);
      #1;
      chk("mr_pop_vec", pop_vec, 32'h0000_0006);
      chk("mr_len", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         chk("mr_word0", 32'(got_q[0]), 32'h20);
         chk("mr_word1", 32'(got_q[1]), 32'h21);
      end

      // Counter wrap over 257 deliveries.
      do_reset_mid();
      clr_obs();
      wrapped  = 1'b0;
      n_pushed = 0;
      for (int g = 0; g < 800 && got_q.size() < 257; g++) begin
         if (n_pushed < 257 && (fq.size() + pend_q.size()) < 4) begin
            push_word(6'(n_pushed));
            n_pushed++;
         end
         step();
      end
      #1;
      chk("wrap_len", 32'(got_q.size()), 32'd257);
      chk("wrap_seen", 32'(wrapped), 32'd1);
      chk("wrap_count", 32'(bus_if.rd_count), 32'd1);
      for (int i = 0; i < got_q.size(); i++) chk("wrap_word", 32'(got_q[i]), 32'(i % 64));

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 1500; i++) begin
         bus_if.enable   = ($urandom_range(3) != 0);
         bus_if.ready_in = ($urandom_range(2) != 0);
         if ((fq.size() + pend_q.size()) < 6 && $urandom_range(1) == 1)
            push_word(6'($urandom));
         if (i == 750) do_reset_mid();
         step();
      end
      bus_if.enable   = 1'b1;
      bus_if.ready_in = 1'b1;
      run(30);
      #1;
      chk("drain_fifo", 32'(fq.size()), 32'd0);
      chk("drain_valid", 32'(bus_if.valid_out), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
